// File: rtl/debounce_bank.sv
// debounce_bank: N-channel debouncer. Each channel has a two-flop synchroniser, a stability
// counter driven by a shared prescaler tick, and rise/fall pulses. Auto-repeat is built with DEBOUNCE_REPEAT_EN.
module debounce_bank #(
  parameter int N            = 4,
  parameter int STABLE       = 31,
  parameter int TICK_DIV     = 1,
  parameter bit INIT         = 1'b1,
  parameter bit ACTIVE_LOW   = 1'b1,
  parameter int REPEAT_DELAY = 250,
  parameter int REPEAT_RATE  = 50
) (
  input  logic         clock,
  input  logic         reset_n,
  input  logic [N-1:0] inp,
  output logic [N-1:0] outp,
  output logic [N-1:0] rise,
  output logic [N-1:0] fall,
  output logic [N-1:0] rpt
);

  localparam int CW = $clog2(STABLE + 1);

  if (STABLE < 1 || TICK_DIV < 1 || REPEAT_DELAY < 1 || REPEAT_RATE < 1 ||
      REPEAT_RATE > REPEAT_DELAY) begin : g_bad_cfg
    $error("debounce_bank: illegal parameter set");
  end

  logic [N-1:0] s1_q, s2_q;

  // NOTE: sequential state always uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      s1_q <= {N{INIT}};
      s2_q <= {N{INIT}};
    end else begin
      s1_q <= inp;
      s2_q <= s1_q;
    end
  end

  logic tick;

  if (TICK_DIV == 1) begin : g_no_div
    assign tick = 1'b1;
  end else begin : g_div
    localparam int PW = $clog2(TICK_DIV);
    logic [PW-1:0] pre_q, pre_d;

    always_comb begin
      pre_d = (pre_q == PW'(TICK_DIV - 1)) ? '0 : pre_q + PW'(1);
    end

    always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) pre_q <= '0;
      else          pre_q <= pre_d;
    end

    assign tick = (pre_q == PW'(TICK_DIV - 1));
  end

  logic [N-1:0][CW-1:0] cnt_q, cnt_d;
  logic [N-1:0]         outp_q, outp_d;
  logic [N-1:0]         rise_q, rise_d;
  logic [N-1:0]         fall_q, fall_d;
  logic [N-1:0]         commit;

  // NOTE: every combinational output gets a default first, so no path leaves it unassigned (no latch).
  always_comb begin
    cnt_d  = cnt_q;
    outp_d = outp_q;
    rise_d = '0;
    fall_d = '0;
    commit = '0;
    for (int i = 0; i < N; i++) begin
      if (s2_q[i] == outp_q[i]) begin
        // Any return to the committed level throws away progress, even on the commit tick.
        cnt_d[i] = '0;
      end else if (tick && cnt_q[i] == CW'(STABLE - 1)) begin
        commit[i] = 1'b1;
        outp_d[i] = s2_q[i];
        cnt_d[i]  = '0;
        rise_d[i] = s2_q[i];
        fall_d[i] = ~s2_q[i];
      end else if (tick) begin
        cnt_d[i] = cnt_q[i] + CW'(1);
      end
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q  <= '0;
      outp_q <= {N{INIT}};
      rise_q <= '0;
      fall_q <= '0;
    end else begin
      cnt_q  <= cnt_d;
      outp_q <= outp_d;
      rise_q <= rise_d;
      fall_q <= fall_d;
    end
  end

  assign outp = outp_q;
  assign rise = rise_q;
  assign fall = fall_q;

`ifdef DEBOUNCE_REPEAT_EN
  localparam int   RW  = $clog2(REPEAT_DELAY + 1);
  localparam logic ACT = ACTIVE_LOW ? 1'b0 : 1'b1;

  logic [N-1:0][RW-1:0] rc_q, rc_d;
  logic [N-1:0]         rpt_q, rpt_d;

  always_comb begin
    rc_d  = rc_q;
    rpt_d = '0;
    for (int i = 0; i < N; i++) begin
      if (outp_q[i] != ACT || commit[i]) begin
        rc_d[i] = '0;
      end else if (tick) begin
        if (rc_q[i] == RW'(REPEAT_DELAY - 1)) begin
          // Reload so the next terminal count is REPEAT_RATE ticks away.
          rpt_d[i] = 1'b1;
          rc_d[i]  = RW'(REPEAT_DELAY - REPEAT_RATE);
        end else begin
          rc_d[i] = rc_q[i] + RW'(1);
        end
      end
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      rc_q  <= '0;
      rpt_q <= '0;
    end else begin
      rc_q  <= rc_d;
      rpt_q <= rpt_d;
    end
  end

  assign rpt = rpt_q;
`else
  assign rpt = '0;
`endif

endmodule

// File: tb/tb_debounce_bank.sv
// Bench for debounce_bank: table-driven level checks plus a pulse scoreboard across three instances
// (base timing, prescaled, fast repeat). Pulse channels 0-3 = dut_a, 4-7 = dut_p, 8-11 = dut_r.
module tb_debounce_bank;

  localparam int LAT = 6;  // drive cycle to pulse cycle with STABLE=4, TICK_DIV=1: capture +1, commit +STABLE+1

  typedef enum logic [1:0] {K_RISE, K_FALL, K_RPT} kind_e;
  typedef struct { int ch; kind_e kind; int lo; int hi; } ev_t;
  typedef struct {
    logic [3:0] inp; int hold; logic [3:0] exp_outp; logic [3:0] exp_rise; logic [3:0] exp_fall; string name;
  } vec_t;

  logic clock = 1'b0;
  logic reset_n = 1'b0;
  logic [3:0] inp_a = 4'hF, inp_p = 4'hF, inp_r = 4'hF;
  logic [3:0] outp_a, rise_a, fall_a, rpt_a;
  logic [3:0] outp_p, rise_p, fall_p, rpt_p;
  logic [3:0] outp_r, rise_r, fall_r, rpt_r;

  int cyc = 0;
  int n_cmp = 0;
  int n_bad = 0;
  int last_hit [12];
  ev_t sb [$];

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  debounce_bank #(.N(4), .STABLE(4), .TICK_DIV(1), .INIT(1'b1), .ACTIVE_LOW(1'b1),
                  .REPEAT_DELAY(250), .REPEAT_RATE(50)) dut_a (
    .clock(clock), .reset_n(reset_n), .inp(inp_a), .outp(outp_a), .rise(rise_a), .fall(fall_a), .rpt(rpt_a));

  debounce_bank #(.N(4), .STABLE(2), .TICK_DIV(3), .INIT(1'b1), .ACTIVE_LOW(1'b1),
                  .REPEAT_DELAY(250), .REPEAT_RATE(50)) dut_p (
    .clock(clock), .reset_n(reset_n), .inp(inp_p), .outp(outp_p), .rise(rise_p), .fall(fall_p), .rpt(rpt_p));

  debounce_bank #(.N(4), .STABLE(4), .TICK_DIV(1), .INIT(1'b1), .ACTIVE_LOW(1'b1),
                  .REPEAT_DELAY(10), .REPEAT_RATE(4)) dut_r (
    .clock(clock), .reset_n(reset_n), .inp(inp_r), .outp(outp_r), .rise(rise_r), .fall(fall_r), .rpt(rpt_r));

  wire [11:0] rise_all = {rise_r, rise_p, rise_a};
  wire [11:0] fall_all = {fall_r, fall_p, fall_a};
  wire [11:0] rpt_all  = {rpt_r, rpt_p, rpt_a};

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic push(input int ch, input kind_e k, input int lo, input int hi);
    ev_t e;
    e.ch = ch; e.kind = k; e.lo = lo; e.hi = hi;
    sb.push_back(e);
  endtask

  task automatic sb_match(input int g, input kind_e k);
    int idx;
    idx = -1;
    foreach (sb[j]) if (idx < 0 && sb[j].ch == g && sb[j].kind == k) idx = j;
    n_cmp++;
    if (idx < 0) begin
      n_bad++;
      $display("FAIL pulse_%s ch%0d: pulse at cycle %0d, none expected", k.name(), g, cyc);
    end else begin
      if (cyc < sb[idx].lo || cyc > sb[idx].hi) begin
        n_bad++;
        $display("FAIL pulse_%s ch%0d: pulse at cycle %0d, expected %0d..%0d", k.name(), g, cyc, sb[idx].lo, sb[idx].hi);
      end
      last_hit[g] = cyc;
      sb.delete(idx);
    end
  endtask

  task automatic sb_expire();
    for (int j = sb.size() - 1; j >= 0; j--) begin
      if (sb[j].hi < cyc) begin
        n_cmp++;
        n_bad++;
        $display("FAIL missed_%s ch%0d: no pulse by cycle %0d, expected %0d..%0d",
                 sb[j].kind.name(), sb[j].ch, cyc, sb[j].lo, sb[j].hi);
        sb.delete(j);
      end
    end
  endtask

  always @(negedge clock) begin
    if (reset_n) begin
      for (int g = 0; g < 12; g++) begin
        if (rise_all[g]) sb_match(g, K_RISE);
        if (fall_all[g]) sb_match(g, K_FALL);
        if (rpt_all[g])  sb_match(g, K_RPT);
      end
      sb_expire();
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  function automatic vec_t mk(input logic [3:0] i, input int h, input logic [3:0] o,
                              input logic [3:0] r, input logic [3:0] f, input string nm);
    vec_t v;
    v.inp = i; v.hold = h; v.exp_outp = o; v.exp_rise = r; v.exp_fall = f; v.name = nm;
    return v;
  endfunction

  vec_t vecs [14];

  initial begin
    int d, r, c, lat, lat_min, lat_max;

    vecs[0]  = mk(4'hF, 8,  4'hF, 4'h0, 4'h0, "idle");
    vecs[1]  = mk(4'hE, 8,  4'hE, 4'h0, 4'h1, "press0");
    vecs[2]  = mk(4'hC, 3,  4'hE, 4'h0, 4'h0, "bounce1_lo_a");
    vecs[3]  = mk(4'hE, 1,  4'hE, 4'h0, 4'h0, "bounce1_hi_a");
    vecs[4]  = mk(4'hC, 3,  4'hE, 4'h0, 4'h0, "bounce1_lo_b");
    vecs[5]  = mk(4'hE, 1,  4'hE, 4'h0, 4'h0, "bounce1_hi_b");
    vecs[6]  = mk(4'hC, 8,  4'hC, 4'h0, 4'h2, "bounce1_hold");
    vecs[7]  = mk(4'h8, 4,  4'hC, 4'h0, 4'h4, "glitch2_four");
    vecs[8]  = mk(4'hC, 10, 4'hC, 4'h4, 4'h0, "glitch2_back");
    vecs[9]  = mk(4'h5, 8,  4'h5, 4'h1, 4'h8, "simul_r0_f3");
    vecs[10] = mk(4'hC, 8,  4'hC, 4'h8, 4'h1, "simul_f0_r3");
    vecs[11] = mk(4'hF, 8,  4'hF, 4'h3, 4'h0, "release_all");
    vecs[12] = mk(4'hB, 3,  4'hF, 4'h0, 4'h0, "glitch2_three");
    vecs[13] = mk(4'hF, 8,  4'hF, 4'h0, 4'h0, "settle");

    // Reset values while held in reset
    step(3);
    check("reset_outp_a", outp_a, 4'hF);
    check("reset_outp_p", outp_p, 4'hF);
    check("reset_pulses", {rise_a, fall_a, rpt_a, rise_p, fall_p, rpt_p, rise_r, fall_r}, 32'h0);
    check("reset_rpt_r", rpt_r, 4'h0);
    reset_n = 1'b1;
    step(4);

    // Table-driven run on dut_a
    foreach (vecs[k]) begin
      d = cyc;
      inp_a = vecs[k].inp;
      for (int b = 0; b < 4; b++) begin
        if (vecs[k].exp_rise[b]) push(b, K_RISE, d + LAT, d + LAT);
        if (vecs[k].exp_fall[b]) push(b, K_FALL, d + LAT, d + LAT);
      end
      step(vecs[k].hold);
      check(vecs[k].name, outp_a, vecs[k].exp_outp);
    end

    // Prescaler latency across three drive phases on dut_p channel 2 (global 6)
    lat_min = 1000;
    lat_max = -1000;
    for (int off = 0; off < 3; off++) begin
      while (cyc % 3 != off) step(1);
      last_hit[6] = -1000;
      d = cyc;
      inp_p = 4'hB;
      push(6, K_FALL, d + 1 + 5, d + 1 + 7);
      step(12);
      lat = last_hit[6] - (d + 1);
      if (lat < lat_min) lat_min = lat;
      if (lat > lat_max) lat_max = lat;
      check("presc_fall_outp", outp_p, 4'hB);
      d = cyc;
      inp_p = 4'hF;
      push(6, K_RISE, d + 1 + 5, d + 1 + 7);
      step(12);
      check("presc_rise_outp", outp_p, 4'hF);
    end
    check("presc_lat_min", lat_min, 5);
    check("presc_lat_max", lat_max, 7);

    // Held press on dut_r channel 0 (global 8): repeats only when the feature is built
    d = cyc;
    c = d + LAT;
    r = d + 30;
    inp_r = 4'hE;
    push(8, K_FALL, c, c);
    push(8, K_RISE, r + LAT, r + LAT);
`ifdef DEBOUNCE_REPEAT_EN
    for (int t = c + 10; t <= r + LAT - 1; t += 4) push(8, K_RPT, t, t);
`endif
    step(30);
    check("repeat_held_outp", outp_r, 4'hE);
    inp_r = 4'hF;
    step(20);
    check("repeat_released_outp", outp_r, 4'hF);

    // Reset asserted mid-count on dut_a, then counting must restart from zero
    inp_a = 4'hE;
    step(3);
    #2 reset_n = 1'b0;
    #1;
    check("midreset_outp_a", outp_a, 4'hF);
    check("midreset_pulses_a", {rise_a, fall_a, rpt_a}, 12'h0);
    inp_a = 4'hF;
    step(2);
    #3 reset_n = 1'b1;
    step(10);
    check("postreset_outp_a", outp_a, 4'hF);
    d = cyc;
    inp_a = 4'hE;
    push(0, K_FALL, d + LAT, d + LAT);
    step(8);
    check("postreset_press", outp_a, 4'hE);
    d = cyc;
    inp_a = 4'hF;
    push(0, K_RISE, d + LAT, d + LAT);
    step(8);
    check("postreset_release", outp_a, 4'hF);

    step(4);
    check("scoreboard_drained", sb.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
